// File: rtl/vga_timing.sv
// VGA raster timing generator.
// A clock divider produces the pixel tick; column/line counters and two
// phase FSMs (horizontal and vertical) derive sync, visible-area and
// frame-start strobes. Every output is a flop on clk, so x/y, syncs and
// valid move together on the same edge and never glitch between ticks.

package vga_timing_pkg;

    typedef enum logic [1:0] {
        H_VIS  = 2'd0,
        H_FP   = 2'd1,
        H_SYNC = 2'd2,
        H_BP   = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_VIS  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } v_state_t;

endpackage

module vga_timing #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pclk_en,
    output logic [9:0] x_cnt,
    output logic [9:0] y_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       frame_start
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last column / line of each phase; the FSM leaves a phase when the
    // counter steps off its last value.
    localparam logic [9:0] H_VIS_LAST  = 10'(H_VISIBLE - 1);
    localparam logic [9:0] H_FP_LAST   = 10'(H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] H_SYNC_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);

    localparam logic [9:0] V_VIS_LAST  = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_FP_LAST   = 10'(V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] V_SYNC_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

    // Divider width: at least one bit so CLK_DIV=1 still has a legal vector.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // With CLK_DIV=1 every clk is a pixel tick, including the reset cycle.
    localparam logic PCLK_RST = (CLK_DIV == 1);

    // ------------------------------------------------------------------
    // Pixel-clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;

    // Divider next value: count 0..CLK_DIV-1 and wrap.
    always_comb begin
        div_next = div_cnt + 1'b1;
        if (div_cnt == DIV_LAST) begin
            div_next = '0;
        end
    end

    // Divider register; pclk_en is a flop that is high while div_cnt sits
    // at its last value, so it is a clean one-clk strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            pclk_en <= PCLK_RST;
        end else begin
            div_cnt <= div_next;
            pclk_en <= (div_next == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Column / line counters
    // ------------------------------------------------------------------
    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_next;
    logic [9:0] y_next;

    // A line ends on the tick that leaves the last column; a frame ends
    // when that happens on the last line.
    always_comb begin
        x_wrap = pclk_en && (x_cnt == H_LAST);
        y_wrap = x_wrap && (y_cnt == V_LAST);
    end

    // Counter next values: x steps every tick, y only on a line wrap.
    always_comb begin
        x_next = x_cnt;
        y_next = y_cnt;
        if (pclk_en) begin
            x_next = x_wrap ? 10'd0 : x_cnt + 10'd1;
        end
        if (x_wrap) begin
            y_next = y_wrap ? 10'd0 : y_cnt + 10'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt <= 10'd0;
            y_cnt <= 10'd0;
        end else begin
            x_cnt <= x_next;
            y_cnt <= y_next;
        end
    end

    // ------------------------------------------------------------------
    // Horizontal phase FSM
    // ------------------------------------------------------------------
    vga_timing_pkg::h_state_t h_state;
    vga_timing_pkg::h_state_t h_next;

    // Horizontal state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_state <= vga_timing_pkg::H_VIS;
        end else begin
            h_state <= h_next;
        end
    end

    // Horizontal next state: advance on the tick that leaves a phase's
    // last column.
    always_comb begin
        h_next = h_state;
        if (pclk_en) begin
            case (h_state)
                vga_timing_pkg::H_VIS:
                    if (x_cnt == H_VIS_LAST)  h_next = vga_timing_pkg::H_FP;
                vga_timing_pkg::H_FP:
                    if (x_cnt == H_FP_LAST)   h_next = vga_timing_pkg::H_SYNC;
                vga_timing_pkg::H_SYNC:
                    if (x_cnt == H_SYNC_LAST) h_next = vga_timing_pkg::H_BP;
                vga_timing_pkg::H_BP:
                    if (x_cnt == H_LAST)      h_next = vga_timing_pkg::H_VIS;
                default:
                    h_next = vga_timing_pkg::H_VIS;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Vertical phase FSM
    // ------------------------------------------------------------------
    vga_timing_pkg::v_state_t v_state;
    vga_timing_pkg::v_state_t v_next;

    // Vertical state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_state <= vga_timing_pkg::V_VIS;
        end else begin
            v_state <= v_next;
        end
    end

    // Vertical next state: same boundary rule on y, stepped by line wraps.
    always_comb begin
        v_next = v_state;
        if (x_wrap) begin
            case (v_state)
                vga_timing_pkg::V_VIS:
                    if (y_cnt == V_VIS_LAST)  v_next = vga_timing_pkg::V_FP;
                vga_timing_pkg::V_FP:
                    if (y_cnt == V_FP_LAST)   v_next = vga_timing_pkg::V_SYNC;
                vga_timing_pkg::V_SYNC:
                    if (y_cnt == V_SYNC_LAST) v_next = vga_timing_pkg::V_BP;
                vga_timing_pkg::V_BP:
                    if (y_cnt == V_LAST)      v_next = vga_timing_pkg::V_VIS;
                default:
                    v_next = vga_timing_pkg::V_VIS;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered strobes
    // ------------------------------------------------------------------
    // Decode from the next FSM state so the strobes land on the same edge
    // as the counters and the state registers they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            valid       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hsync       <= (h_next != vga_timing_pkg::H_SYNC);
            vsync       <= (v_next != vga_timing_pkg::V_SYNC);
            valid       <= (h_next == vga_timing_pkg::H_VIS) &&
                           (v_next == vga_timing_pkg::V_VIS);
            frame_start <= y_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. Three instances share clk/rst: the
// default 640x480 geometry at CLK_DIV=4, and a tiny 15x9 raster at
// CLK_DIV=4 and CLK_DIV=1 so full frames fit in a short run. Expected
// values come from clock-edge arithmetic: after k edges since release,
// t = k/CLK_DIV ticks have elapsed, x = t mod H_TOTAL, y = (t/H_TOTAL) mod V_TOTAL.

module tb_vga_timing;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int k     = 0;   // rising edges since the last reset release

    // Default geometry, CLK_DIV=4.
    logic       pe_a, hs_a, vs_a, va_a, fs_a;
    logic [9:0] x_a, y_a;
    // Small raster 8/2/3/2 x 4/1/2/2, CLK_DIV=4.
    logic       pe_b, hs_b, vs_b, va_b, fs_b;
    logic [9:0] x_b, y_b;
    // Small raster, CLK_DIV=1.
    logic       pe_c, hs_c, vs_c, va_c, fs_c;
    logic [9:0] x_c, y_c;

    vga_timing u_a (
        .clk(clk), .rst(rst), .pclk_en(pe_a), .x_cnt(x_a), .y_cnt(y_a),
        .hsync(hs_a), .vsync(vs_a), .valid(va_a), .frame_start(fs_a)
    );

    vga_timing #(
        .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_b (
        .clk(clk), .rst(rst), .pclk_en(pe_b), .x_cnt(x_b), .y_cnt(y_b),
        .hsync(hs_b), .vsync(vs_b), .valid(va_b), .frame_start(fs_b)
    );

    vga_timing #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) u_c (
        .clk(clk), .rst(rst), .pclk_en(pe_c), .x_cnt(x_c), .y_cnt(y_c),
        .hsync(hs_c), .vsync(vs_c), .valid(va_c), .frame_start(fs_c)
    );

    // Expected {x, y, hsync, vsync, valid, pclk_en, frame_start} after k edges.
    function automatic logic [24:0] exp_vec(input int kk, input int dv,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb);
        int   ht, vt, t, x, y;
        logic pe, fs, hsn, vsn, vld;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        t   = kk / dv;
        x   = t % ht;
        y   = (t / ht) % vt;
        pe  = ((kk % dv) == dv - 1);
        fs  = (kk > 0) && ((kk % dv) == 0) && ((t % (ht * vt)) == 0);
        hsn = !((x >= hv + hf) && (x < hv + hf + hs));
        vsn = !((y >= vv + vf) && (y < vv + vf + vs));
        vld = (x < hv) && (y < vv);
        return {10'(x), 10'(y), hsn, vsn, vld, pe, fs};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        k++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k   = 0;
    endtask

    // Reset values appear without a clock edge and hold across edges.
    task automatic test_reset();
        logic [24:0] got;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        got = {x_a, y_a, hs_a, vs_a, va_a, pe_a, fs_a};
        n_vec++;
        if (got !== {10'd0, 10'd0, 5'b11100}) begin
            n_err++; $display("FAIL reset_a got=%h want=%h", got, {10'd0, 10'd0, 5'b11100});
        end
        got = {x_b, y_b, hs_b, vs_b, va_b, pe_b, fs_b};
        n_vec++;
        if (got !== {10'd0, 10'd0, 5'b11100}) begin
            n_err++; $display("FAIL reset_b got=%h want=%h", got, {10'd0, 10'd0, 5'b11100});
        end
        got = {x_c, y_c, hs_c, vs_c, va_c, pe_c, fs_c};
        n_vec++;
        if (got !== {10'd0, 10'd0, 5'b11110}) begin
            n_err++; $display("FAIL reset_c got=%h want=%h", got, {10'd0, 10'd0, 5'b11110});
        end
        repeat (3) @(negedge clk);
        got = {x_a, y_a, hs_a, vs_a, va_a, pe_a, fs_a};
        n_vec++;
        if (got !== {10'd0, 10'd0, 5'b11100}) begin
            n_err++; $display("FAIL reset_hold_a got=%h want=%h", got, {10'd0, 10'd0, 5'b11100});
        end
        rst = 1'b1;
        k   = 0;
    endtask

    // First pixel tick: pclk_en high into the 4th edge, x=1 after it.
    task automatic test_pclk_start();
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++;
            if ({pe_a, x_a} !== {(i == 3), ((i == 4) ? 10'd1 : 10'd0)}) begin
                n_err++;
                $display("FAIL pclk_start_a edge=%0d got pe=%b x=%0d want pe=%b x=%0d",
                         i, pe_a, x_a, (i == 3), (i == 4) ? 1 : 0);
            end
            n_vec++;
            if ({pe_c, x_c} !== {1'b1, 10'(i)}) begin
                n_err++;
                $display("FAIL pclk_start_c edge=%0d got pe=%b x=%0d want pe=1 x=%0d", i, pe_c, x_c, i);
            end
        end
    endtask

    // One full 800-pixel line on the default geometry, every clk checked.
    task automatic test_line();
        logic [24:0] got, want;
        int hs_low  = 0;
        int fall_x  = -1;
        while (k < 3210) begin
            tick();
            got  = {x_a, y_a, hs_a, vs_a, va_a, pe_a, fs_a};
            want = exp_vec(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
            n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL line k=%0d got=%h want=%h", k, got, want);
            end
            if (k <= 3200 && !hs_a) hs_low++;
            if (fall_x < 0 && !va_a) fall_x = int'(x_a);
            if (k == 3199 || k == 3200) begin
                n_vec++;
                if ({x_a, y_a} !== ((k == 3199) ? {10'd799, 10'd0} : {10'd0, 10'd1})) begin
                    n_err++; $display("FAIL line_wrap k=%0d got x=%0d y=%0d", k, x_a, y_a);
                end
            end
        end
        n_vec++;
        if (hs_low != 384) begin
            n_err++; $display("FAIL hsync_width got=%0d clks want=384", hs_low);
        end
        n_vec++;
        if (fall_x != 640) begin
            n_err++; $display("FAIL valid_fall got x=%0d want x=640", fall_x);
        end
    endtask

    // Two full frames on the small raster at CLK_DIV=4 (540 clks each).
    task automatic test_frame();
        logic [24:0] got, want;
        int fs_cnt = 0;
        int vs_min = 99;
        int vs_max = -1;
        int y_max  = 0;
        do_reset();
        while (k < 1090) begin
            tick();
            got  = {x_b, y_b, hs_b, vs_b, va_b, pe_b, fs_b};
            want = exp_vec(k, 4, 8, 2, 3, 2, 4, 1, 2, 2);
            n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL frame k=%0d got=%h want=%h", k, got, want);
            end
            if (fs_b) fs_cnt++;
            if (!vs_b && int'(y_b) < vs_min) vs_min = int'(y_b);
            if (!vs_b && int'(y_b) > vs_max) vs_max = int'(y_b);
            if (int'(y_b) > y_max) y_max = int'(y_b);
            if (k == 540 || k == 541) begin
                n_vec++;
                if (fs_b !== (k == 540)) begin
                    n_err++; $display("FAIL frame_start_edge k=%0d got=%b want=%b", k, fs_b, (k == 540));
                end
            end
        end
        n_vec++;
        if (fs_cnt != 2) begin
            n_err++; $display("FAIL frame_start_count got=%0d want=2", fs_cnt);
        end
        n_vec++;
        if (vs_min != 5 || vs_max != 6) begin
            n_err++; $display("FAIL vsync_lines got=%0d..%0d want=5..6", vs_min, vs_max);
        end
        n_vec++;
        if (y_max != 8) begin
            n_err++; $display("FAIL y_max got=%0d want=8", y_max);
        end
    endtask

    // CLK_DIV=1: pclk_en never drops, frame every 135 clks.
    task automatic test_clkdiv1();
        logic [24:0] got, want;
        int pe_low   = 0;
        int fs_first = -1;
        int fs_cnt   = 0;
        do_reset();
        while (k < 273) begin
            tick();
            got  = {x_c, y_c, hs_c, vs_c, va_c, pe_c, fs_c};
            want = exp_vec(k, 1, 8, 2, 3, 2, 4, 1, 2, 2);
            n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL div1 k=%0d got=%h want=%h", k, got, want);
            end
            if (!pe_c) pe_low++;
            if (fs_c) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
            end
        end
        n_vec++;
        if (pe_low != 0) begin
            n_err++; $display("FAIL div1_pclk_low got=%0d clks want=0", pe_low);
        end
        n_vec++;
        if (fs_first != 135 || fs_cnt != 2) begin
            n_err++; $display("FAIL div1_period got first=%0d count=%0d want first=135 count=2", fs_first, fs_cnt);
        end
    endtask

    // Reset mid-frame: immediate reset values, restart from (0,0).
    task automatic test_reset_mid();
        logic [24:0] got, want;
        do_reset();
        while (k < 1210) tick();
        n_vec++;
        if ({x_a, y_a, x_b, y_b} !== {10'd302, 10'd0, 10'd2, 10'd2}) begin
            n_err++;
            $display("FAIL mid_pos got a=(%0d,%0d) b=(%0d,%0d) want a=(302,0) b=(2,2)", x_a, y_a, x_b, y_b);
        end
        #1 rst = 1'b0;
        #1;
        got = {x_a, y_a, hs_a, vs_a, va_a, pe_a, fs_a};
        n_vec++;
        if (got !== {10'd0, 10'd0, 5'b11100}) begin
            n_err++; $display("FAIL mid_reset_a got=%h want=%h", got, {10'd0, 10'd0, 5'b11100});
        end
        got = {x_b, y_b, hs_b, vs_b, va_b, pe_b, fs_b};
        n_vec++;
        if (got !== {10'd0, 10'd0, 5'b11100}) begin
            n_err++; $display("FAIL mid_reset_b got=%h want=%h", got, {10'd0, 10'd0, 5'b11100});
        end
        @(negedge clk);
        rst = 1'b1;
        k   = 0;
        while (k < 8) begin
            tick();
            got  = {x_a, y_a, hs_a, vs_a, va_a, pe_a, fs_a};
            want = exp_vec(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
            n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL mid_restart_a k=%0d got=%h want=%h", k, got, want);
            end
            got  = {x_b, y_b, hs_b, vs_b, va_b, pe_b, fs_b};
            want = exp_vec(k, 4, 8, 2, 3, 2, 4, 1, 2, 2);
            n_vec++;
            if (got !== want) begin
                n_err++; $display("FAIL mid_restart_b k=%0d got=%h want=%h", k, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pclk_start();
        test_line();
        test_frame();
        test_clkdiv1();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
